// File: rtl/door_access_if.sv
// Handshake bundle between the door access sequencer and its surrounding datapath.
interface door_access_if;
    logic       enter;
    logic       success;
    logic       change_req;
    logic       change_done;
    logic       enter_gated;
    logic       door_open;
    logic       locked_out;
    logic       alarm;
    logic       change_grant;
    logic [2:0] fail_count;
    logic [2:0] state;

    modport master (
        output enter, success, change_req, change_done,
        input  enter_gated, door_open, locked_out, alarm, change_grant, fail_count, state
    );

    modport slave (
        input  enter, success, change_req, change_done,
        output enter_gated, door_open, locked_out, alarm, change_grant, fail_count, state
    );
endinterface

// File: rtl/door_access_controller.sv
// Door access sequencer: enter edge strobe, timed password check, unlock window,
// failed-attempt lockout with sticky alarm, and password-change grant.
module door_access_controller #(
    parameter int unsigned CHECK_LAT     = 2,
    parameter int unsigned UNLOCK_CYCLES = 50,
    parameter int unsigned LOCK_CYCLES   = 100,
    parameter int unsigned MAX_FAIL      = 3,
    parameter int unsigned ALARM_LOCKS   = 2
) (
    input  logic         clk,
    input  logic         reset,
    door_access_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_UNLOCK  = 3'd2,
        ST_CHANGE  = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_ALARM   = 3'd5
    } state_t;

    localparam int unsigned MAX_T_A = (CHECK_LAT > UNLOCK_CYCLES) ? CHECK_LAT : UNLOCK_CYCLES;
    localparam int unsigned MAX_T   = (MAX_T_A > LOCK_CYCLES) ? MAX_T_A : LOCK_CYCLES;
    localparam int unsigned TIMER_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [2:0]           fail_q, fail_d, fail_inc;
    logic [2:0]           locks_q, locks_d, locks_inc;
    logic                 enter_q;
    logic                 rise;
    logic                 gated_q, gated_d;
    logic                 door_q, door_d;
    logic                 locked_q, locked_d;
    logic                 alarm_q, alarm_d;
    logic                 grant_q, grant_d;

    assign rise      = bus.enter & ~enter_q;
    assign fail_inc  = (fail_q  == 3'd7) ? fail_q  : fail_q  + 3'd1;
    assign locks_inc = (locks_q == 3'd7) ? locks_q : locks_q + 3'd1;

    // Timers are loaded with duration-1 on entry and the state exits when they read zero.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        locks_d = locks_q;
        gated_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_CHECK;
                    timer_d = TIMER_W'(CHECK_LAT - 1);
                    gated_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (bus.success) begin
                    state_d = ST_UNLOCK;
                    timer_d = TIMER_W'(UNLOCK_CYCLES - 1);
                    fail_d  = 3'd0;
                    locks_d = 3'd0;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == 3'(MAX_FAIL)) begin
                        locks_d = locks_inc;
                        if (locks_inc == 3'(ALARM_LOCKS)) begin
                            state_d = ST_ALARM;
                        end else begin
                            state_d = ST_LOCKOUT;
                            timer_d = TIMER_W'(LOCK_CYCLES - 1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNLOCK: begin
                if (bus.change_req) begin
                    state_d = ST_CHANGE;
                end else if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_CHANGE: begin
                if (bus.change_done) state_d = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (timer_q == '0) begin
                    fail_d  = 3'd0;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_ALARM: begin
                state_d = ST_ALARM;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        door_d   = (state_d == ST_UNLOCK);
        locked_d = (state_d == ST_LOCKOUT) || (state_d == ST_ALARM);
        alarm_d  = (state_d == ST_ALARM);
        grant_d  = (state_d == ST_CHANGE);
    end

    // Edge register follows enter even in reset so a held button cannot fire afterwards.
    always_ff @(posedge clk) begin
        enter_q <= bus.enter;
        if (reset) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            fail_q   <= 3'd0;
            locks_q  <= 3'd0;
            gated_q  <= 1'b0;
            door_q   <= 1'b0;
            locked_q <= 1'b0;
            alarm_q  <= 1'b0;
            grant_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            fail_q   <= fail_d;
            locks_q  <= locks_d;
            gated_q  <= gated_d;
            door_q   <= door_d;
            locked_q <= locked_d;
            alarm_q  <= alarm_d;
            grant_q  <= grant_d;
        end
    end

    assign bus.enter_gated  = gated_q;
    assign bus.door_open    = door_q;
    assign bus.locked_out   = locked_q;
    assign bus.alarm        = alarm_q;
    assign bus.change_grant = grant_q;
    assign bus.fail_count   = fail_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_door_access_controller.sv
// Scoreboard bench for door_access_controller: stimulus queues expected outputs per cycle,
// a monitor pops and compares them and checks every enter_gated pulse against its expected cycle.
module tb_door_access_controller;
    localparam int unsigned U = 8;
    localparam int unsigned L = 6;

    localparam int K_STATE  = 0;
    localparam int K_DOOR   = 1;
    localparam int K_LOCK   = 2;
    localparam int K_ALARM  = 3;
    localparam int K_GRANT  = 4;
    localparam int K_FAIL   = 5;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    int    exp_cyc[$];
    int    exp_kind[$];
    int    exp_val[$];
    string exp_name[$];
    int    gate_q[$];

    door_access_if bus ();

    door_access_controller #(
        .CHECK_LAT(2), .UNLOCK_CYCLES(U), .LOCK_CYCLES(L), .MAX_FAIL(3), .ALARM_LOCKS(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int k);
        case (k)
            K_STATE: return int'(bus.state);
            K_DOOR:  return int'(bus.door_open);
            K_LOCK:  return int'(bus.locked_out);
            K_ALARM: return int'(bus.alarm);
            K_GRANT: return int'(bus.change_grant);
            default: return int'(bus.fail_count);
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, and every strobe the DUT presents.
    always @(negedge clk) begin : monitor
        int i;
        int a;
        int g;
        i = 0;
        while (i < exp_cyc.size()) begin
            if (exp_cyc[i] == cyc) begin
                a = actual(exp_kind[i]);
                checks++;
                if (a == exp_val[i]) passed++;
                else $display("FAIL %s @cycle %0d: got %0d, expected %0d", exp_name[i], cyc, a, exp_val[i]);
                exp_cyc.delete(i);
                exp_kind.delete(i);
                exp_val.delete(i);
                exp_name.delete(i);
            end else begin
                i++;
            end
        end
        if (bus.enter_gated === 1'b1) begin
            checks++;
            if (gate_q.size() == 0) begin
                $display("FAIL enter_gated @cycle %0d: got unexpected pulse, expected none", cyc);
            end else begin
                g = gate_q.pop_front();
                if (g == cyc) passed++;
                else $display("FAIL enter_gated @cycle %0d: got pulse, expected it at cycle %0d", cyc, g);
            end
        end
    end

    task automatic exp_at(input int c, input int k, input int v, input string n);
        exp_cyc.push_back(c);
        exp_kind.push_back(k);
        exp_val.push_back(v);
        exp_name.push_back(n);
    endtask

    task automatic exp_cleared(input int c, input string n);
        exp_at(c, K_STATE, 0, {n, "_state"});
        exp_at(c, K_DOOR,  0, {n, "_door"});
        exp_at(c, K_LOCK,  0, {n, "_locked"});
        exp_at(c, K_ALARM, 0, {n, "_alarm"});
        exp_at(c, K_GRANT, 0, {n, "_grant"});
        exp_at(c, K_FAIL,  0, {n, "_fail"});
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One failed check starting with a rise at cycle r; expected outcomes are pushed by the caller.
    task automatic fail_attempt(input int r);
        wait_until(r);
        bus.enter = 1'b1;
        gate_q.push_back(r + 1);
        wait_until(r + 1);
        bus.enter = 1'b0;
    endtask

    initial begin : stimulus
        int c;
        int r;
        reset = 1'b1;
        bus.enter = 1'b0;
        bus.success = 1'b0;
        bus.change_req = 1'b0;
        bus.change_done = 1'b0;
        wait_until(3);
        exp_cleared(cyc, "reset");
        reset = 1'b0;

        // Latency, held button, and a rise during UNLOCK.
        c = cyc + 2;
        wait_until(c);
        exp_at(c + 1, K_STATE, 1, "lat_check1");
        exp_at(c + 2, K_STATE, 1, "lat_check2");
        exp_at(c + 2, K_DOOR, 0, "lat_door_pre");
        exp_at(c + 3, K_DOOR, 1, "lat_door_first");
        exp_at(c + 3, K_STATE, 2, "lat_unlock");
        exp_at(c + 3, K_FAIL, 0, "lat_fail");
        exp_at(c + 3 + U - 1, K_DOOR, 1, "lat_door_last");
        exp_at(c + 3 + U, K_DOOR, 0, "lat_door_after");
        exp_at(c + 3 + U, K_STATE, 0, "lat_idle");
        exp_at(c + 21, K_STATE, 0, "held_still_idle");
        gate_q.push_back(c + 1);
        bus.enter = 1'b1;
        wait_until(c + 2);  bus.success = 1'b1;
        wait_until(c + 3);  bus.success = 1'b0;
        wait_until(c + 6);  bus.enter = 1'b0;
        wait_until(c + 7);  bus.enter = 1'b1;
        wait_until(c + 20); bus.enter = 1'b0;

        // Three failed checks: fail_count 1, 2, then lockout for exactly L cycles.
        c = c + 23;
        exp_at(c + 3, K_FAIL, 1, "lk_fail1");
        exp_at(c + 3, K_STATE, 0, "lk_idle1");
        fail_attempt(c);
        exp_at(c + 8, K_FAIL, 2, "lk_fail2");
        exp_at(c + 8, K_STATE, 0, "lk_idle2");
        fail_attempt(c + 5);
        r = c + 10;
        exp_at(r + 2, K_LOCK, 0, "lk_locked_pre");
        exp_at(r + 3, K_LOCK, 1, "lk_locked_first");
        exp_at(r + 3, K_STATE, 4, "lk_state");
        exp_at(r + 3, K_FAIL, 3, "lk_fail3");
        exp_at(r + 3 + L - 1, K_LOCK, 1, "lk_locked_last");
        exp_at(r + 3 + L, K_LOCK, 0, "lk_locked_after");
        exp_at(r + 3 + L, K_STATE, 0, "lk_idle_after");
        exp_at(r + 3 + L, K_FAIL, 0, "lk_fail_clear");
        fail_attempt(r);
        wait_until(r + 5); bus.enter = 1'b1;
        wait_until(r + 6); bus.enter = 1'b0;

        // Second lockout sequence goes straight to ALARM and stays there.
        c = r + 3 + L + 2;
        exp_at(c + 3, K_FAIL, 1, "al_fail1");
        fail_attempt(c);
        exp_at(c + 8, K_FAIL, 2, "al_fail2");
        fail_attempt(c + 5);
        r = c + 10;
        exp_at(r + 3, K_STATE, 5, "al_state");
        exp_at(r + 3, K_ALARM, 1, "al_alarm");
        exp_at(r + 3, K_LOCK, 1, "al_locked");
        exp_at(r + 3, K_FAIL, 3, "al_fail3");
        exp_at(r + 103, K_ALARM, 1, "al_alarm_sticky");
        exp_at(r + 103, K_STATE, 5, "al_state_sticky");
        exp_at(r + 103, K_FAIL, 3, "al_fail_hold");
        fail_attempt(r);
        wait_until(r + 5); bus.enter = 1'b1;
        wait_until(r + 6); bus.enter = 1'b0;
        wait_until(r + 105); reset = 1'b1;
        wait_until(r + 106); reset = 1'b0;
        exp_cleared(r + 106, "al_reset");

        // change_req in IDLE is ignored; change_req on the expiry cycle of UNLOCK wins.
        c = r + 108;
        wait_until(c); bus.change_req = 1'b1;
        exp_at(c + 1, K_STATE, 0, "chg_idle_ignore");
        exp_at(c + 1, K_GRANT, 0, "chg_idle_nogrant");
        wait_until(c + 1); bus.change_req = 1'b0;
        r = c + 2;
        exp_at(r + 3 + U - 1, K_DOOR, 1, "chg_door_last");
        exp_at(r + 3 + U, K_STATE, 3, "chg_state");
        exp_at(r + 3 + U, K_GRANT, 1, "chg_grant");
        exp_at(r + 3 + U, K_DOOR, 0, "chg_door_off");
        exp_at(r + 3 + U + 3, K_STATE, 3, "chg_hold");
        exp_at(r + 3 + U + 4, K_STATE, 0, "chg_done_idle");
        exp_at(r + 3 + U + 4, K_GRANT, 0, "chg_done_nogrant");
        wait_until(r); bus.enter = 1'b1;
        gate_q.push_back(r + 1);
        wait_until(r + 1); bus.enter = 1'b0;
        wait_until(r + 2); bus.success = 1'b1;
        wait_until(r + 3); bus.success = 1'b0;
        wait_until(r + 3 + U - 1); bus.change_req = 1'b1;
        wait_until(r + 3 + U);     bus.change_req = 1'b0;
        wait_until(r + 3 + U + 1); bus.enter = 1'b1;
        wait_until(r + 3 + U + 2); bus.enter = 1'b0;
        wait_until(r + 3 + U + 3); bus.change_done = 1'b1;
        wait_until(r + 3 + U + 4); bus.change_done = 1'b0;

        // Reset mid-UNLOCK with the timer at 3 while enter is held across reset.
        r = r + 3 + U + 6;
        exp_at(r + 7, K_DOOR, 1, "rst_door_before");
        exp_at(r + 8, K_DOOR, 0, "rst_door_off");
        exp_at(r + 8, K_STATE, 0, "rst_state");
        exp_at(r + 11, K_STATE, 0, "rst_held_idle");
        wait_until(r); bus.enter = 1'b1;
        gate_q.push_back(r + 1);
        wait_until(r + 1);  bus.enter = 1'b0;
        wait_until(r + 2);  bus.success = 1'b1;
        wait_until(r + 3);  bus.success = 1'b0;
        wait_until(r + 6);  bus.enter = 1'b1;
        wait_until(r + 7);  reset = 1'b1;
        wait_until(r + 8);  reset = 1'b0;
        wait_until(r + 12); bus.enter = 1'b0;
        wait_until(r + 15);

        checks++;
        if (gate_q.size() == 0) passed++;
        else $display("FAIL enter_gated_missing: got %0d pulses outstanding, expected 0", gate_q.size());
        checks++;
        if (exp_cyc.size() == 0) passed++;
        else $display("FAIL unchecked_expectations: got %0d outstanding, expected 0", exp_cyc.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
